// File: rtl/regfile_mp_bypass.sv
// Multi-port bypassing integer register file; reads are 0-cycle combinational, writes land on the next edge.
// No backpressure: after reset a zeroing sweep runs, and ready_o gates both writes and reads.
module regfile_mp_bypass #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rdAddr_i,
  output logic [NRD*XLEN-1:0] rdData_o,
  input  logic                we0_i,
  input  logic [AW-1:0]       wAddr0_i,
  input  logic [XLEN-1:0]     wData0_i,
  input  logic                we1_i,
  input  logic [AW-1:0]       wAddr1_i,
  input  logic [XLEN-1:0]     wData1_i,
  output logic                ready_o
);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   mem_q [NREG];
  logic              wr_ok0, wr_ok1;
  logic [AW-1:0]     ra;

  // Addresses past NREG, and x0 when hard-wired, neither store nor bypass.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok0  = we0_i && addr_ok(wAddr0_i);
  assign wr_ok1  = we1_i && addr_ok(wAddr1_i);
  assign ready_o = ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
      end else begin
        if (wr_ok0) mem_q[wAddr0_i] <= wData0_i;
        if (wr_ok1) mem_q[wAddr1_i] <= wData1_i;
      end
    end
  end

  always_comb begin
    rdData_o = '0;
    ra       = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rdAddr_i[i*AW +: AW];
      if ((state_q == RUN) && addr_ok(ra)) begin
        if (we1_i && (wAddr1_i == ra))      rdData_o[i*XLEN +: XLEN] = wData1_i;
        else if (we0_i && (wAddr0_i == ra)) rdData_o[i*XLEN +: XLEN] = wData0_i;
        else                                rdData_o[i*XLEN +: XLEN] = mem_q[ra];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Two register-file configurations share one stimulus stream; a scoreboard checks ready and every read lane.
module tb_regfile_mp_bypass;

  localparam int NRD = 4;
  localparam int AW  = 5;
  localparam int NREG_M [2] = '{32, 24};
  localparam bit ZR_M   [2] = '{1'b1, 1'b0};

  typedef struct packed {
    logic [1:0]   rdy;
    logic [127:0] da;
    logic [127:0] db;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [19:0]   rdAddr;
  logic          we0, we1;
  logic [4:0]    wAddr0, wAddr1;
  logic [31:0]   wData0, wData1;
  logic [127:0]  rdData_a, rdData_b;
  logic          ready_a, ready_b;

  int total = 0;
  int bad   = 0;

  exp_t        expq [$];
  bit          known = 1'b0;
  bit          m_rdy  [2];
  int          m_left [2];
  logic [31:0] mem_m  [2][32];

  regfile_mp_bypass #(.XLEN(32), .NREG(32), .NRD(NRD), .ZERO_REG(1)) u_a (
    .clk_i(clk), .rst_i(rst), .rdAddr_i(rdAddr), .rdData_o(rdData_a),
    .we0_i(we0), .wAddr0_i(wAddr0), .wData0_i(wData0),
    .we1_i(we1), .wAddr1_i(wAddr1), .wData1_i(wData1), .ready_o(ready_a));

  regfile_mp_bypass #(.XLEN(32), .NREG(24), .NRD(NRD), .ZERO_REG(0)) u_b (
    .clk_i(clk), .rst_i(rst), .rdAddr_i(rdAddr), .rdData_o(rdData_b),
    .we0_i(we0), .wAddr0_i(wAddr0), .wData0_i(wData0),
    .we1_i(we1), .wAddr1_i(wAddr1), .wData1_i(wData1), .ready_o(ready_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit valid(input int d, input logic [4:0] a);
    return (int'(a) < NREG_M[d]) && !(ZR_M[d] && a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_lane(input int d, input logic [4:0] a,
      input logic e0, input logic [4:0] a0, input logic [31:0] d0,
      input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    if (!m_rdy[d] || !valid(d, a)) return 32'h0;
    if (e1 && a1 == a) return d1;
    if (e0 && a0 == a) return d0;
    return mem_m[d][a];
  endfunction

  function automatic logic [19:0] mk_ra(input int l0, input int l1, input int l2, input int l3);
    return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
  endfunction

  task automatic step(input logic r,
      input logic e0, input logic [4:0] a0, input logic [31:0] d0,
      input logic e1, input logic [4:0] a1, input logic [31:0] d1,
      input logic [19:0] ra);
    exp_t e;
    rst = r; we0 = e0; wAddr0 = a0; wData0 = d0;
    we1 = e1; wAddr1 = a1; wData1 = d1; rdAddr = ra;
    if (known) begin
      e.rdy = {m_rdy[1], m_rdy[0]};
      for (int l = 0; l < NRD; l++) begin
        e.da[l*32 +: 32] = exp_lane(0, ra[l*AW +: AW], e0, a0, d0, e1, a1, d1);
        e.db[l*32 +: 32] = exp_lane(1, ra[l*AW +: AW], e0, a0, d0, e1, a1, d1);
      end
      expq.push_back(e);
    end
    // Effect of the coming rising edge on the reference model.
    if (r) begin
      known = 1'b1;
      for (int d = 0; d < 2; d++) begin
        m_left[d] = NREG_M[d];
        m_rdy[d]  = 1'b0;
      end
    end else if (known) begin
      for (int d = 0; d < 2; d++) begin
        if (!m_rdy[d]) begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_rdy[d] = 1'b1;
            for (int k = 0; k < 32; k++) mem_m[d][k] = 32'h0;
          end
        end else begin
          if (e0 && valid(d, a0)) mem_m[d][a0] = d0;
          if (e1 && valid(d, a1)) mem_m[d][a1] = d1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("A.ready", {31'b0, ready_a}, {31'b0, e.rdy[0]});
      chk("B.ready", {31'b0, ready_b}, {31'b0, e.rdy[1]});
      for (int l = 0; l < NRD; l++) begin
        chk($sformatf("A.lane%0d", l), rdData_a[l*32 +: 32], e.da[l*32 +: 32]);
        chk($sformatf("B.lane%0d", l), rdData_b[l*32 +: 32], e.db[l*32 +: 32]);
      end
    end
  end

  initial begin
    logic [4:0]  a0, a1;
    logic [19:0] ra;
    int          pick;
    // One-cycle reset pulse, then sweep while trying to write x5.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, mk_ra(5, 0, 1, 31));
    for (int i = 0; i < 40; i++)
      step(1'b0, (i < 24), 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
           mk_ra(5, 5, i % 32, $urandom_range(0, 31)));
    // Write-through then array read.
    step(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'h0, mk_ra(7, 5, 7, 0));
    step(1'b0, 1'b0, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(7, 7, 7, 7));
    // Collision on x9, then distinct addresses.
    step(1'b0, 1'b1, 5'd9, 32'hAAAA0000, 1'b1, 5'd9, 32'h5555FFFF, mk_ra(9, 9, 9, 9));
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(9, 7, 0, 9));
    step(1'b0, 1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444, mk_ra(3, 4, 3, 4));
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(3, 4, 9, 7));
    // Register 0: hard-wired on A, ordinary on B.
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, mk_ra(0, 0, 0, 0));
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(0, 0, 0, 0));
    // Out of range on B (address 30), then multi-lane bypass.
    step(1'b0, 1'b1, 5'd30, 32'hC0FFEE00, 1'b1, 5'd30, 32'hC0FFEE11, mk_ra(30, 30, 24, 31));
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(30, 30, 23, 24));
    step(1'b0, 1'b1, 5'd2, 32'h22222222, 1'b1, 5'd23, 32'h23232323, mk_ra(2, 23, 1, 0));
    step(1'b0, 1'b1, 5'd1, 32'h11111111, 1'b0, 5'd0, 32'h0, mk_ra(1, 1, 2, 23));
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(1, 1, 2, 23));
    // Reset mid-sweep; x11 written in RUN must read 0 afterwards.
    step(1'b0, 1'b1, 5'd11, 32'hBEEF0011, 1'b0, 5'd0, 32'h0, mk_ra(11, 0, 0, 0));
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(11, 7, 0, 0));
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 5'(i), 32'h5A5A0000 + i, 1'b1, 5'(i + 10), 32'hA5A50000 + i, mk_ra(11, i, i + 10, 7));
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(11, 7, 0, 0));
    for (int i = 0; i < 36; i++)
      step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, mk_ra(11, 7, i % 32, 9));
    // Randomised traffic with biased collisions and read-after-write.
    for (int i = 0; i < 600; i++) begin
      a0 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
      ra = '0;
      for (int l = 0; l < NRD; l++) begin
        pick = $urandom_range(0, 3);
        ra[l*AW +: AW] = (pick == 0) ? a0 : (pick == 1) ? a1 : 5'($urandom_range(0, 31));
      end
      step(($urandom_range(0, 199) == 0), 1'($urandom), a0, $urandom,
           1'($urandom), a1, $urandom, ra);
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
